// File: rtl/w5300_bus_master.sv
// Single-access bus master for the W5300 16-bit direct-address parallel interface.
// Generates CS/WR/RD/OE with parameterised phase lengths and synchronises INT_n.
module w5300_bus_master #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [10:0] addr,
  input  logic [15:0] wr_data,
  output logic        op_state,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic [9:0]  bus_addr,
  output logic [15:0] bus_data_o,
  output logic        bus_data_oe,
  input  logic [15:0] bus_data_i,
  output logic        bus_cs_n,
  output logic        bus_wr_n,
  output logic        bus_rd_n,
  input  logic        int_n,
  output logic        irq
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  // Phase counter is loaded with length-1 on entry and the state ends when it reaches zero.
  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYC - 1);

  state_t     state;
  logic [3:0] phase_cnt;
  logic       dir_wr;
  logic [1:0] int_sync;

  assign busy = (state != IDLE);
  assign irq  = int_sync[1];

  // Bus controls are set on the edge that enters each phase so every pin comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      phase_cnt   <= 4'd0;
      dir_wr      <= 1'b0;
      op_state    <= 1'b0;
      rd_data     <= 16'd0;
      bus_addr    <= 10'd0;
      bus_data_o  <= 16'd0;
      bus_data_oe <= 1'b0;
      bus_cs_n    <= 1'b1;
      bus_wr_n    <= 1'b1;
      bus_rd_n    <= 1'b1;
    end else begin
      op_state <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state     <= SETUP;
            phase_cnt <= SETUP_LD;
            dir_wr    <= addr[10];
            bus_addr  <= addr[9:0];
            bus_cs_n  <= 1'b0;
            if (addr[10]) begin
              bus_data_o  <= wr_data;
              bus_data_oe <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (phase_cnt == 4'd0) begin
            state     <= STROBE;
            phase_cnt <= STROBE_LD;
            bus_wr_n  <= ~dir_wr;
            bus_rd_n  <= dir_wr;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        STROBE: begin
          if (phase_cnt == 4'd0) begin
            state     <= HOLD;
            phase_cnt <= HOLD_LD;
            bus_wr_n  <= 1'b1;
            bus_rd_n  <= 1'b1;
            if (!dir_wr) rd_data <= bus_data_i;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        HOLD: begin
          if (phase_cnt == 4'd0) begin
            state       <= RECOVER;
            phase_cnt   <= RECOVER_LD;
            bus_cs_n    <= 1'b1;
            bus_data_oe <= 1'b0;
            op_state    <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        RECOVER: begin
          if (phase_cnt == 4'd0) state <= IDLE;
          else phase_cnt <= phase_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) int_sync <= 2'b00;
    else     int_sync <= {int_sync[0], ~int_n};
  end

endmodule

// File: tb/tb_w5300_bus_master.sv
// Self-checking bench for w5300_bus_master: default instance plus a parameter-sweep instance,
// both compared cycle by cycle against a phase-timeline model of the access.
module tb_w5300_bus_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_a, req_b, int_n_a, int_n_b;
  logic [10:0] addr_a, addr_b;
  logic [15:0] wrd_a, wrd_b, di_a, di_b;
  logic        op_a, op_b, busy_a, busy_b, oe_a, oe_b, cs_a, cs_b, wr_a, wr_b, rd_a, rd_b, irq_a, irq_b;
  logic [15:0] rdd_a, rdd_b, dout_a, dout_b;
  logic [9:0]  baddr_a, baddr_b;

  typedef struct packed {
    logic cs_n, wr_n, rd_n, oe, op, busy;
    logic [9:0]  baddr;
    logic [15:0] dout, rdd;
  } obs_t;

  int checks = 0;
  int passes = 0;
  logic [15:0] rd_model [2];

  w5300_bus_master dut_a (
    .clk(clk), .rst(rst), .req(req_a), .addr(addr_a), .wr_data(wrd_a),
    .op_state(op_a), .rd_data(rdd_a), .busy(busy_a), .bus_addr(baddr_a),
    .bus_data_o(dout_a), .bus_data_oe(oe_a), .bus_data_i(di_a),
    .bus_cs_n(cs_a), .bus_wr_n(wr_a), .bus_rd_n(rd_a), .int_n(int_n_a), .irq(irq_a)
  );

  w5300_bus_master #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2), .RECOVER_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .addr(addr_b), .wr_data(wrd_b),
    .op_state(op_b), .rd_data(rdd_b), .busy(busy_b), .bus_addr(baddr_b),
    .bus_data_o(dout_b), .bus_data_oe(oe_b), .bus_data_i(di_b),
    .bus_cs_n(cs_b), .bus_wr_n(wr_b), .bus_rd_n(rd_b), .int_n(int_n_b), .irq(irq_b)
  );

  task automatic set_in(input bit sel, input logic r, input logic [10:0] a,
                        input logic [15:0] d, input logic [15:0] di);
    if (!sel) begin req_a = r; addr_a = a; wrd_a = d; di_a = di; end
    else      begin req_b = r; addr_b = a; wrd_b = d; di_b = di; end
  endtask

  function automatic obs_t get_obs(input bit sel);
    if (!sel) return {cs_a, wr_a, rd_a, oe_a, op_a, busy_a, baddr_a, dout_a, rdd_a};
    return {cs_b, wr_b, rd_b, oe_b, op_b, busy_b, baddr_b, dout_b, rdd_b};
  endfunction

  // Expected pins in cycle k after acceptance (k=0), from the phase lengths alone.
  function automatic void model(input int k, input int s, input int st, input int h, input int r,
                                input bit dir, input logic [9:0] a, input logic [15:0] d,
                                input logic [15:0] rd_old, input logic [15:0] rd_new,
                                output obs_t e, output obs_t m);
    int last;
    bit on, stb;
    last = s + st + h;
    on   = (k >= 1 && k <= last);
    stb  = (k >= s + 1 && k <= s + st);
    e = '0;
    m = '1;
    e.cs_n  = !on;
    e.wr_n  = !(stb && dir);
    e.rd_n  = !(stb && !dir);
    e.oe    = on && dir;
    e.op    = (k == last + 1);
    e.busy  = (k >= 1 && k <= last + r);
    e.baddr = a;
    if (!(k >= 1 && k <= last + r)) m.baddr = '0;
    e.dout = d;
    if (!(on && dir)) m.dout = '0;
    e.rdd = (!dir && k > s + st) ? rd_new : rd_old;
  endfunction

  // One access; with chain=1 it returns in the IDLE cycle so the next call is accepted there.
  task automatic run_access(input bit sel, input bit dir, input logic [9:0] a, input logic [15:0] d,
                            input logic [15:0] di_s, input logic [15:0] di_h, input bit chain,
                            input string name);
    int s, st, h, r, total;
    obs_t o, e, m;
    logic [15:0] rd_old, rd_new;
    if (sel) begin s = 3; st = 1; h = 2; r = 1; end
    else     begin s = 1; st = 4; h = 1; r = 2; end
    total  = s + st + h + r;
    rd_old = rd_model[sel];
    rd_new = dir ? rd_old : di_s;
    set_in(sel, 1'b1, {dir, a}, d, di_h);
    for (int k = 1; k <= total + 1; k++) begin
      @(posedge clk); #1;
      o = get_obs(sel);
      model(k, s, st, h, r, dir, a, d, rd_old, rd_new, e, m);
      checks++;
      if (((o ^ e) & m) !== '0)
        $display("[TB] FAIL %s cycle %0d: got %h expected %h mask %h", name, k, o, e, m);
      else passes++;
      if (k <= total)
        set_in(sel, 1'($urandom), 11'($urandom), 16'($urandom),
               (k >= s + 1 && k <= s + st) ? di_s : di_h);
    end
    rd_model[sel] = rd_new;
    if (!chain) begin
      set_in(sel, 1'b0, 11'($urandom), 16'($urandom), 16'($urandom));
      @(posedge clk); #1;
      o = get_obs(sel);
      checks++;
      if (o.busy !== 1'b0 || o.cs_n !== 1'b1)
        $display("[TB] FAIL %s idle_after: busy=%b cs_n=%b expected busy=0 cs_n=1", name, o.busy, o.cs_n);
      else passes++;
    end
  endtask

  task automatic test_reset;
    obs_t exp_rst;
    exp_rst = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0, 16'd0};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int sel = 0; sel < 2; sel++) begin
      checks++;
      if (get_obs(1'(sel)) !== exp_rst)
        $display("[TB] FAIL reset_state dut%0d: got %h expected %h", sel, get_obs(1'(sel)), exp_rst);
      else passes++;
    end
    checks++;
    if ({irq_a, irq_b} !== 2'b00) $display("[TB] FAIL reset_irq: got %b expected 00", {irq_a, irq_b});
    else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (get_obs(1'b0) !== exp_rst)
      $display("[TB] FAIL after_release: got %h expected %h", get_obs(1'b0), exp_rst);
    else passes++;
    rd_model[0] = 16'd0;
    rd_model[1] = 16'd0;
  endtask

  task automatic test_write;
    run_access(1'b0, 1'b1, 10'h008, 16'h08DC, 16'h1234, 16'h4321, 1'b0, "write_default");
  endtask

  task automatic test_read;
    run_access(1'b0, 1'b0, 10'h3FE, 16'hAAAA, 16'h5300, 16'hFFFF, 1'b0, "read_default");
  endtask

  task automatic test_random_access;
    for (int i = 0; i < 6; i++)
      run_access(1'b0, 1'($urandom), 10'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 i < 5, "random_default");
  endtask

  task automatic test_param_sweep;
    for (int i = 0; i < 4; i++)
      run_access(1'b1, 1'(i), 10'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 i < 3, "sweep");
  endtask

  // req held high: accesses accepted at cycles 0, 9, 18 alternating write/read/write.
  task automatic test_back_to_back;
    logic [9:0]  a [3];
    logic [15:0] d [3];
    bit          dir [3];
    logic [15:0] rd_seq [4];
    logic [15:0] di;
    obs_t o, e, m;
    int n, rel;
    dir = '{1'b1, 1'b0, 1'b1};
    di  = 16'($urandom);
    for (int i = 0; i < 3; i++) begin a[i] = 10'($urandom); d[i] = 16'($urandom); end
    rd_seq[0] = rd_model[0];
    rd_seq[1] = rd_model[0];
    rd_seq[2] = di;
    rd_seq[3] = di;
    set_in(1'b0, 1'b1, {dir[0], a[0]}, d[0], di);
    for (int k = 1; k <= 29; k++) begin
      @(posedge clk); #1;
      n = (k - 1) / 9;
      if (n > 2) n = 2;
      rel = k - 9 * n;
      o = get_obs(1'b0);
      model(rel, 1, 4, 1, 2, dir[n], a[n], d[n], rd_seq[n], rd_seq[n + 1], e, m);
      checks++;
      if (((o ^ e) & m) !== '0)
        $display("[TB] FAIL back_to_back cycle %0d: got %h expected %h mask %h", k, o, e, m);
      else passes++;
      if (k == 9 || k == 18) set_in(1'b0, 1'b1, {dir[k / 9], a[k / 9]}, d[k / 9], di);
      else set_in(1'b0, k < 19, 11'($urandom), 16'($urandom), di);
    end
    rd_model[0] = di;
  endtask

  task automatic test_reset_mid_strobe;
    obs_t exp_rst;
    exp_rst = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0, 16'd0};
    set_in(1'b0, 1'b1, {1'b1, 10'h155}, 16'hBEEF, 16'h0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      set_in(1'b0, 1'b0, {1'b1, 10'h155}, 16'hBEEF, 16'h0);
    end
    checks++;
    if (wr_a !== 1'b0) $display("[TB] FAIL mid_strobe_precondition: wr_n=%b expected 0", wr_a);
    else passes++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (get_obs(1'b0) !== exp_rst)
      $display("[TB] FAIL reset_abort: got %h expected %h", get_obs(1'b0), exp_rst);
    else passes++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (get_obs(1'b0) !== exp_rst)
        $display("[TB] FAIL reset_hold %0d: got %h expected %h", k, get_obs(1'b0), exp_rst);
      else passes++;
    end
    rst = 1'b0;
    rd_model[0] = 16'd0;
    rd_model[1] = 16'd0;
    @(posedge clk); #1;
    run_access(1'b0, 1'b0, 10'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, "after_abort_rd");
    run_access(1'b0, 1'b1, 10'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, "after_abort_wr");
  endtask

  task automatic test_interrupt;
    @(posedge clk); #3;
    int_n_a = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (irq_a !== 1'b0) $display("[TB] FAIL irq_one_edge: got %b expected 0", irq_a); else passes++;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq_a !== 1'b1) $display("[TB] FAIL irq_assert: got %b expected 1", irq_a); else passes++;
    #3 int_n_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq_a !== 1'b0) $display("[TB] FAIL irq_release: got %b expected 0", irq_a); else passes++;
    int_n_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (irq_a !== 1'b0) $display("[TB] FAIL irq_in_reset: got %b expected 0", irq_a); else passes++;
    int_n_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq_a !== 1'b0) $display("[TB] FAIL irq_after_reset: got %b expected 0", irq_a); else passes++;
    rd_model[0] = 16'd0;
    rd_model[1] = 16'd0;
  endtask

  initial begin
    int_n_a = 1'b1;
    int_n_b = 1'b1;
    set_in(1'b0, 1'b0, 11'd0, 16'd0, 16'd0);
    set_in(1'b1, 1'b0, 11'd0, 16'd0, 16'd0);
    test_reset();
    test_write();
    test_read();
    test_random_access();
    test_back_to_back();
    test_param_sweep();
    test_reset_mid_strobe();
    test_interrupt();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
